btn_step_conditioner: RTL and testbench
=======================================

# btn_step_conditioner

Input conditioner feeding the signed LED step counter. It takes the raw east/west pushbuttons and produces clean, single-cycle step pulses: east decrements the counter, west increments it. The block synchronises, debounces and arbitrates both buttons, and adds hold-to-repeat. Its outputs drive the counter's step inputs directly, so the counter needs no timing logic of its own.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a clean level changes (20 ms at 50 MHz). Must be at least 1.
- REPEAT_DELAY, 25_000_000: cycles from the first pulse to the first auto-repeat pulse. Must be at least 1.
- REPEAT_PERIOD, 5_000_000: cycles between auto-repeat pulses. Must be at least 1.
- clk  in  1  system clock; the block's only clock.
- reset  in  1  asynchronous, active-low reset.
- btn_east  in  1  raw east button, active-high, asynchronous to clk.
- btn_west  in  1  raw west button, active-high, asynchronous to clk.
- step_dn  out  1  one-cycle pulse requesting a decrement (east).
- step_up  out  1  one-cycle pulse requesting an increment (west).
- east_clean  out  1  debounced east level.
- west_clean  out  1  debounced west level.
- lockout  out  1  high while both buttons are pressed, or while waiting for both to be released.

## Operation
- Reset low: every flop clears immediately, all outputs are 0, the FSM is in IDLE and the timers are 0.
- Synchroniser: 2-flop synchroniser per button; the debouncer uses only the second flop.
- Debounce, per button:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets to 0 on any cycle where the synced input equals the clean level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the clean level toggles on that edge and the counter clears.
- FSM states: IDLE, HOLD, REPEAT, LOCKOUT. It holds a dir register (EAST/WEST) and a timer.
  - IDLE, east_clean only: pulse step_dn; dir=EAST; timer=0; go to HOLD.
  - IDLE, west_clean only: pulse step_up; dir=WEST; timer=0; go to HOLD.
  - IDLE, both clean levels high on the same cycle: go to LOCKOUT with no pulse.
  - HOLD or REPEAT, other button's clean level rises: go to LOCKOUT with no pulse. This is checked first.
  - HOLD or REPEAT, dir button's clean level falls: go to IDLE with no pulse.
  - HOLD, timer reaches REPEAT_DELAY-1: pulse; timer=0; go to REPEAT.
  - REPEAT, timer reaches REPEAT_PERIOD-1: pulse; timer=0.
  - LOCKOUT: stay until both clean levels are 0, then go to IDLE. No pulses are produced in LOCKOUT.
- Pulse rules:
  - step_up and step_dn are never high together.
  - Each pulse lasts exactly one cycle.
  - Both are registered outputs.
- Timer width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). The timer never wraps; it is always cleared on a state change.
- Reset asserted mid-hold: outputs clear at once. After reset is released, a button still held is debounced again as a new press and produces a new first pulse.

## Timing
- Raw press, stable from before edge 0:
  - synced high after edge 2;
  - clean high after edge 2+DEBOUNCE_CYCLES;
  - first pulse high for the cycle after edge 3+DEBOUNCE_CYCLES.
- Release follows the same path: the clean level falls 2+DEBOUNCE_CYCLES edges after the raw release.
- Held button pulse spacing:
  - the second pulse comes REPEAT_DELAY cycles after the first;
  - each later pulse comes REPEAT_PERIOD cycles after the previous one.
- Bounce: a glitch shorter than DEBOUNCE_CYCLES cycles produces no change in the clean level and no pulse.
- Reset: outputs are 0 combinationally-immediately on assertion. The first possible pulse comes no earlier than 3+DEBOUNCE_CYCLES edges after deassertion.

## Structure
- Package btn_pkg holds:
  - the FSM state enum (IDLE, HOLD, REPEAT, LOCKOUT);
  - the dir enum (EAST, WEST);
  - a width helper function for the counters.
- Sub-module btn_debounce, instantiated twice, one per button:
  - contains the 2-flop synchroniser and the debounce counter;
  - parameter DEBOUNCE_CYCLES;
  - ports clk, reset, raw, clean.
- The top level holds the FSM, dir, timer and pulse registers.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Single press: raise btn_west at edge 0 and hold it for 8 cycles, then release. Required: exactly one step_up, high for the cycle after edge 7; no step_dn.
- Bounce: btn_east toggles at 2-cycle intervals five times, then stays high. Required: east_clean rises only after 4 stable synced cycles; exactly one step_dn.
- Auto-repeat: hold btn_east for 40 cycles after the first pulse. Required: step_dn pulses at first+0, +10, +13, +16 … +40; the pulses stop within 6 cycles of release.
- Simultaneous press: raise both buttons on the same edge. Required: lockout rises, no step pulses occur, and lockout clears after both clean levels fall. A following west press then produces step_up.
- Cross press: hold west into REPEAT, then press east. Required: lockout is entered, step_up stops, and no step_dn occurs.
- Reset mid-hold: pull reset low during REPEAT. Required: all outputs are 0 immediately. After reset is released with btn_west still held, exactly one new step_up occurs 7 edges later.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and sizing helper for the pushbutton step conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRepeat,
        StLockout
    } btn_state_e;

    typedef enum logic {
        DirEast,
        DirWest
    } btn_dir_e;

    // Bits needed for a counter that must be able to hold max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-run debouncer for one raw button.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          clean_q, clean_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle that agrees with the clean level restarts the stability run.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (sync2_q != clean_q) begin
            if (cnt_q == CntLast) begin
                clean_d = ~clean_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/btn_step_conditioner.sv
// Turns debounced east/west buttons into arbitrated one-cycle step pulses with
// hold-to-repeat; pressing both buttons locks out stepping until both are released.
module btn_step_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_east,
    input  logic btn_west,
    output logic step_dn,
    output logic step_up,
    output logic east_clean,
    output logic west_clean,
    output logic lockout
);

    localparam int unsigned TimerMax =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW = cnt_width(TimerMax);
    localparam logic [TW-1:0] DelayLast  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PeriodLast = TW'(REPEAT_PERIOD - 1);

    btn_state_e    state_q, state_d;
    btn_dir_e      dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          up_q, up_d, dn_q, dn_d;
    logic          pulse;
    logic          dir_level, other_level;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_east (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_east),
        .clean(east_clean)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_west (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_west),
        .clean(west_clean)
    );

    assign dir_level   = (dir_q == DirEast) ? east_clean : west_clean;
    assign other_level = (dir_q == DirEast) ? west_clean : east_clean;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        pulse   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (east_clean && west_clean) begin
                    state_d = StLockout;
                end else if (east_clean || west_clean) begin
                    pulse   = 1'b1;
                    dir_d   = east_clean ? DirEast : DirWest;
                    timer_d = '0;
                    state_d = StHold;
                end
            end
            StHold, StRepeat: begin
                // A cross press wins over release and over any due repeat.
                if (other_level) begin
                    state_d = StLockout;
                    timer_d = '0;
                end else if (!dir_level) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (timer_q == ((state_q == StHold) ? DelayLast : PeriodLast)) begin
                    pulse   = 1'b1;
                    timer_d = '0;
                    state_d = StRepeat;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StLockout: begin
                if (!east_clean && !west_clean) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
        up_d = pulse && (dir_d == DirWest);
        dn_d = pulse && (dir_d == DirEast);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            dir_q   <= DirEast;
            timer_q <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    assign step_up = up_q;
    assign step_dn = dn_q;
    assign lockout = (state_q == StLockout);

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Scoreboard bench: a cycle model predicts pulse times, a monitor matches DUT pulses.
module tb_btn_step_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    localparam int MFree   = 0;
    localparam int MHeld   = 1;
    localparam int MLocked = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_east = 1'b0;
    logic btn_west = 1'b0;
    logic step_dn, step_up, east_clean, west_clean, lockout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        int dir;
    } pulse_t;
    pulse_t exp_q[$];

    // Model state: index 0 is east, 1 is west.
    bit m_s1[2];
    bit m_s2[2];
    bit m_cl[2];
    int m_run[2];
    int m_mode = MFree;
    int m_dir = 0;
    int m_age = 0;

    int up_cnt = 0, dn_cnt = 0, lock_cnt = 0;
    int last_up = -1, last_dn = -1;

    btn_step_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_east  (btn_east),
        .btn_west  (btn_west),
        .step_dn   (step_dn),
        .step_up   (step_up),
        .east_clean(east_clean),
        .west_clean(west_clean),
        .lockout   (lockout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int d);
        pulse_t p;
        p.cyc = cyc;
        p.dir = d;
        exp_q.push_back(p);
    endtask

    // One clock edge of the reference behaviour, using pre-edge levels throughout.
    task automatic model_edge();
        bit e, w, mine, other;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 1'b0;
                m_s2[i] = 1'b0;
                m_cl[i] = 1'b0;
                m_run[i] = 0;
            end
            m_mode = MFree;
            m_dir = 0;
            m_age = 0;
            return;
        end
        e = m_cl[0];
        w = m_cl[1];
        case (m_mode)
            MFree: begin
                if (e && w) begin
                    m_mode = MLocked;
                end else if (e || w) begin
                    m_dir = e ? 0 : 1;
                    m_mode = MHeld;
                    m_age = 0;
                    expect_pulse(m_dir);
                end
            end
            MHeld: begin
                mine = (m_dir == 0) ? e : w;
                other = (m_dir == 0) ? w : e;
                if (other) begin
                    m_mode = MLocked;
                end else if (!mine) begin
                    m_mode = MFree;
                end else begin
                    m_age++;
                    if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0))
                        expect_pulse(m_dir);
                end
            end
            default: begin
                if (!e && !w) m_mode = MFree;
            end
        endcase
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != m_cl[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_cl[i] = ~m_cl[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2[0] = m_s1[0];
        m_s2[1] = m_s1[1];
        m_s1[0] = btn_east;
        m_s1[1] = btn_west;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_edge();
        end
    end

    // Monitor: compares levels every cycle and matches each pulse against the queue.
    initial begin
        pulse_t e;
        bit here;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("outputs_in_reset",
                    int'({step_dn, step_up, east_clean, west_clean, lockout}), 0);
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    chk("missed_pulse", 0, 1);
                    void'(exp_q.pop_front());
                end
                chk("pulse_exclusive", int'(step_up && step_dn), 0);
                chk("east_clean", int'(east_clean), int'(m_cl[0]));
                chk("west_clean", int'(west_clean), int'(m_cl[1]));
                chk("lockout", int'(lockout), int'(m_mode == MLocked));
                here = (exp_q.size() > 0 && exp_q[0].cyc == cyc);
                if (step_up || step_dn) begin
                    if (!here) begin
                        chk("unexpected_pulse", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_up", int'(step_up), e.dir);
                        chk("pulse_dn", int'(step_dn), 1 - e.dir);
                    end
                end else if (here) begin
                    chk("missed_pulse", 0, 1);
                    void'(exp_q.pop_front());
                end
                if (step_up) begin
                    up_cnt++;
                    last_up = cyc;
                end
                if (step_dn) begin
                    dn_cnt++;
                    last_dn = cyc;
                end
                if (lockout) lock_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int u0, d0, l0, p, q;
        #1;
        chk("reset_state", int'({step_dn, step_up, east_clean, west_clean, lockout}), 0);
        tick(3);
        reset = 1'b1;
        tick(2);

        // Single west press held 8 cycles.
        u0 = up_cnt; d0 = dn_cnt; p = cyc + 1;
        btn_west = 1'b1;
        tick(8);
        btn_west = 1'b0;
        tick(14);
        chk("single_up_count", up_cnt - u0, 1);
        chk("single_dn_count", dn_cnt - d0, 0);
        chk("single_up_time", last_up - (p - 1), 3 + D);

        // Bouncing east: five 2-cycle toggles ending high.
        u0 = up_cnt; d0 = dn_cnt; p = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            btn_east = ~btn_east;
            tick(2);
        end
        tick(4);
        btn_east = 1'b0;
        tick(14);
        chk("bounce_dn_count", dn_cnt - d0, 1);
        chk("bounce_up_count", up_cnt - u0, 0);
        chk("bounce_dn_time", last_dn - p, 14);

        // East auto-repeat held 40 cycles past the first pulse.
        d0 = dn_cnt; p = cyc + 1;
        btn_east = 1'b1;
        tick(47);
        btn_east = 1'b0;
        tick(16);
        chk("repeat_dn_count", dn_cnt - d0, 14);
        chk("repeat_stops_after_release", int'(last_dn - (p + 47) <= 6), 1);

        // Simultaneous press locks out, then a west press works again.
        u0 = up_cnt; d0 = dn_cnt; l0 = lock_cnt;
        btn_east = 1'b1;
        btn_west = 1'b1;
        tick(10);
        btn_east = 1'b0;
        btn_west = 1'b0;
        tick(14);
        chk("simul_no_up", up_cnt - u0, 0);
        chk("simul_no_dn", dn_cnt - d0, 0);
        chk("simul_lockout_seen", int'(lock_cnt - l0 > 0), 1);
        chk("simul_lockout_clear", int'(lockout), 0);
        u0 = up_cnt;
        btn_west = 1'b1;
        tick(8);
        btn_west = 1'b0;
        tick(14);
        chk("post_lock_up_count", up_cnt - u0, 1);

        // West into repeat, then east pressed across it.
        u0 = up_cnt; d0 = dn_cnt; l0 = lock_cnt; p = cyc + 1;
        btn_west = 1'b1;
        tick(18);
        btn_east = 1'b1;
        tick(12);
        btn_east = 1'b0;
        btn_west = 1'b0;
        tick(16);
        chk("cross_up_count", up_cnt - u0, 4);
        chk("cross_no_dn", dn_cnt - d0, 0);
        chk("cross_lockout_seen", int'(lock_cnt - l0 > 0), 1);
        chk("cross_up_stopped", int'(last_up <= p + 18 + D + 2), 1);

        // Reset during repeat with west still held.
        btn_west = 1'b1;
        tick(20);
        #2 reset = 1'b0;
        #1 chk("reset_immediate",
               int'({step_dn, step_up, east_clean, west_clean, lockout}), 0);
        tick(3);
        reset = 1'b1;
        u0 = up_cnt; q = cyc + 1;
        tick(8);
        btn_west = 1'b0;
        tick(14);
        chk("post_reset_up_count", up_cnt - u0, 1);
        chk("post_reset_up_time", last_up - (q - 1), 3 + D);

        // Random button activity checked only by the model.
        for (int i = 0; i < 30; i++) begin
            btn_east = 1'($urandom_range(0, 1));
            btn_west = 1'($urandom_range(0, 1));
            tick(int'($urandom_range(1, 25)));
        end
        btn_east = 1'b0;
        btn_west = 1'b0;
        tick(24);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
